// File: rtl/res_bcd_display_if.sv
// Result/display bundle between the calculator core, the BCD display block and the board pins.
// The master side drives the result and load strobe; the slave side converts and drives the display.
interface res_bcd_display_if;
    logic [7:0]  res;
    logic        load;
    logic        busy;
    logic [11:0] digits;
    logic [6:0]  seg;
    logic [2:0]  an;

    modport master (output res, load, input  busy, digits, seg, an);
    modport slave  (input  res, load, output busy, digits, seg, an);
endinterface

// File: rtl/res_bcd_display.sv
// Sequential double-dabble binary-to-BCD converter driving a 3-digit multiplexed
// common-anode seven-segment display with leading-zero blanking.
module res_bcd_display #(
    parameter int REFRESH_DIV = 16
) (
    input  logic               clk,
    input  logic               reset,
    res_bcd_display_if.slave   bus
);
    localparam int             CW   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0]  LAST = CW'(REFRESH_DIV - 1);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_bin, w_bin_nxt;
    logic [11:0] r_bcd, w_bcd_nxt, w_adj;
    logic [2:0]  r_cnt, w_cnt_nxt;
    logic [11:0] r_digits, w_digits_nxt;

    // Add-3 correction per nibble; 4-bit wrap is safe since nibbles never exceed 9.
    for (genvar g = 0; g < 3; g++) begin : g_adj
        assign w_adj[4*g +: 4] = (r_bcd[4*g +: 4] >= 4'd5) ? r_bcd[4*g +: 4] + 4'd3
                                                            : r_bcd[4*g +: 4];
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_bin_nxt    = r_bin;
        w_bcd_nxt    = r_bcd;
        w_cnt_nxt    = r_cnt;
        w_digits_nxt = r_digits;
        case (r_state)
            IDLE: begin
                if (bus.load) begin
                    w_bin_nxt   = bus.res;
                    w_bcd_nxt   = 12'h000;
                    w_cnt_nxt   = 3'd0;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                w_bcd_nxt = {w_adj[10:0], r_bin[7]};
                w_bin_nxt = {r_bin[6:0], 1'b0};
                w_cnt_nxt = r_cnt + 3'd1;
                if (r_cnt == 3'd7) begin
                    w_digits_nxt = {w_adj[10:0], r_bin[7]};
                    w_state_nxt  = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_bin    <= 8'h00;
            r_bcd    <= 12'h000;
            r_cnt    <= 3'd0;
            r_digits <= 12'h000;
        end else begin
            r_state  <= w_state_nxt;
            r_bin    <= w_bin_nxt;
            r_bcd    <= w_bcd_nxt;
            r_cnt    <= w_cnt_nxt;
            r_digits <= w_digits_nxt;
        end
    end

    assign bus.busy   = (r_state == SHIFT);
    assign bus.digits = r_digits;

    // Scan: 0=units, 1=tens, 2=hundreds; free-running, independent of conversions.
    logic [CW-1:0] r_refresh;
    logic [1:0]    r_sel;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_refresh <= '0;
            r_sel     <= 2'd0;
        end else if (r_refresh == LAST) begin
            r_refresh <= '0;
            r_sel     <= (r_sel == 2'd2) ? 2'd0 : r_sel + 2'd1;
        end else begin
            r_refresh <= r_refresh + 1'b1;
        end
    end

    logic [2:0] w_an;
    logic [3:0] w_nib;
    logic       w_blank;
    logic [6:0] w_seg;
    logic       w_h_zero, w_t_zero;

    assign w_h_zero = (r_digits[11:8] == 4'd0);
    assign w_t_zero = (r_digits[7:4]  == 4'd0);

    always_comb begin
        w_an    = 3'b110;
        w_nib   = r_digits[3:0];
        w_blank = 1'b0;
        case (r_sel)
            2'd1: begin
                w_an    = 3'b101;
                w_nib   = r_digits[7:4];
                w_blank = w_h_zero && w_t_zero;
            end
            2'd2: begin
                w_an    = 3'b011;
                w_nib   = r_digits[11:8];
                w_blank = w_h_zero;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_seg = 7'b1111111;
        case (w_nib)
            4'd0: w_seg = 7'b1000000;
            4'd1: w_seg = 7'b1111001;
            4'd2: w_seg = 7'b0100100;
            4'd3: w_seg = 7'b0110000;
            4'd4: w_seg = 7'b0011001;
            4'd5: w_seg = 7'b0010010;
            4'd6: w_seg = 7'b0000010;
            4'd7: w_seg = 7'b1111000;
            4'd8: w_seg = 7'b0000000;
            4'd9: w_seg = 7'b0010000;
            default: w_seg = 7'b1111111;
        endcase
        if (w_blank) w_seg = 7'b1111111;
    end

    assign bus.an  = w_an;
    assign bus.seg = w_seg;
endmodule
